// File: rtl/rambus_pkg.sv
// Shared definitions for the RAM-bus arbiter: default widths, the state
// encoding and the data word returned to a master on a bus timeout.
package rambus_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 16;

  // Word handed back to a master whose transfer was never acked by the RAM
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Arbiter state encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rambus_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the master that was not served last
// wins; with a single requester that requester wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  // Resolve the winner from the request vector and the last-served index
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/rambus_arbiter.sv
// Wishbone arbiter sharing one RAM port between the Caravel bridge (M0) and
// the generator sample fetch (M1). One transfer at a time, round-robin
// between masters, with a wait-cycle timeout that completes a hung transfer
// with a marker data word.
module rambus_arbiter
  import rambus_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  // Master 0: Caravel bridge
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_dat_o,
  // Master 1: generator sample fetch
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_dat_o,
  // RAM side
  output logic              rambus_wb_clk_o,
  output logic              rambus_wb_rst_o,
  output logic              rambus_wb_cyc_o,
  output logic              rambus_wb_stb_o,
  output logic              rambus_wb_we_o,
  output logic [3:0]        rambus_wb_sel_o,
  output logic [ADDR_W-1:0] rambus_wb_adr_o,
  output logic [DATA_W-1:0] rambus_wb_dat_o,
  input  logic              rambus_wb_ack_i,
  input  logic [DATA_W-1:0] rambus_wb_dat_i,
  // Status
  output logic              grant_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [0:0] S_IDLE = ST_IDLE;
  localparam logic [0:0] S_BUSY = ST_BUSY;

  logic [0:0]        state_r;
  logic              grant_r;
  logic              last_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [1:0]        req_s;
  logic              winner_s;
  logic              busy_s;
  logic              g_cyc_s;
  logic              g_stb_s;
  logic              g_we_s;
  logic [3:0]        g_sel_s;
  logic [ADDR_W-1:0] g_adr_s;
  logic [DATA_W-1:0] g_dat_s;
  logic              abort_s;
  logic              ack_s;
  logic              tmo_s;
  logic              done_s;
  logic              resp_ack_s;
  logic [DATA_W-1:0] resp_dat_s;

  assign req_s  = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign busy_s = (state_r == S_BUSY);

  rr_pick2 u_pick (
    .req    (req_s),
    .last   (last_r),
    .winner (winner_s)
  );

  // Mux the granted master's request fields
  always_comb begin
    g_cyc_s = 1'b0;
    g_stb_s = 1'b0;
    g_we_s  = 1'b0;
    g_sel_s = 4'h0;
    g_adr_s = '0;
    g_dat_s = '0;
    if (grant_r) begin
      g_cyc_s = m1_cyc_i;
      g_stb_s = m1_stb_i;
      g_we_s  = m1_we_i;
      g_sel_s = m1_sel_i;
      g_adr_s = m1_adr_i;
      g_dat_s = m1_dat_i;
    end else begin
      g_cyc_s = m0_cyc_i;
      g_stb_s = m0_stb_i;
      g_we_s  = m0_we_i;
      g_sel_s = m0_sel_i;
      g_adr_s = m0_adr_i;
      g_dat_s = m0_dat_i;
    end
  end

  // Classify how the current transfer ends; a real ack beats the timeout
  always_comb begin
    abort_s = busy_s & ~g_cyc_s;
    ack_s   = busy_s & g_cyc_s & rambus_wb_ack_i;
    tmo_s   = busy_s & g_cyc_s & ~rambus_wb_ack_i & (cnt_r == CNT_LAST);
    done_s  = abort_s | ack_s | tmo_s;
  end

  // Drive the RAM bus from the granted master while busy, zeros otherwise
  always_comb begin
    rambus_wb_cyc_o = 1'b0;
    rambus_wb_stb_o = 1'b0;
    rambus_wb_we_o  = 1'b0;
    rambus_wb_sel_o = 4'h0;
    rambus_wb_adr_o = '0;
    rambus_wb_dat_o = '0;
    if (busy_s) begin
      rambus_wb_cyc_o = g_cyc_s;
      rambus_wb_stb_o = g_stb_s & ~tmo_s;
      rambus_wb_we_o  = g_we_s;
      rambus_wb_sel_o = g_sel_s;
      rambus_wb_adr_o = g_adr_s;
      rambus_wb_dat_o = g_dat_s;
    end else begin
      rambus_wb_cyc_o = 1'b0;
      rambus_wb_stb_o = 1'b0;
    end
  end

  // Route the response (real or timeout marker) to the granted master only
  always_comb begin
    resp_ack_s = ack_s | tmo_s;
    resp_dat_s = tmo_s ? DATA_W'(TIMEOUT_DATA) : rambus_wb_dat_i;
    m0_ack_o   = 1'b0;
    m0_dat_o   = '0;
    m1_ack_o   = 1'b0;
    m1_dat_o   = '0;
    if (busy_s && grant_r) begin
      m1_ack_o = resp_ack_s;
      m1_dat_o = resp_dat_s;
    end else if (busy_s) begin
      m0_ack_o = resp_ack_s;
      m0_dat_o = resp_dat_s;
    end else begin
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
    end
  end

  // Grant/release FSM with round-robin memory and wait-cycle counter
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_r <= S_IDLE;
      grant_r <= 1'b0;
      last_r  <= 1'b1;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (|req_s) begin
            state_r <= S_BUSY;
            grant_r <= winner_s;
            cnt_r   <= '0;
          end
        end
        S_BUSY: begin
          if (done_s) begin
            state_r <= S_IDLE;
            last_r  <= grant_r;
            cnt_r   <= '0;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = ~wb_rst_ni;
  assign grant_o         = grant_r;
  assign busy_o          = busy_s;
  assign timeout_o       = tmo_s;

endmodule

// File: tb/tb_rambus_arbiter.sv
// Randomized scoreboard bench for rambus_arbiter. Masters push the response
// they expect when they issue a transfer; a negedge monitor checks the bus
// routing, arbitration order and pops responses as acks appear.
module tb_rambus_arbiter;

  localparam int TMO = 16;

  typedef struct {
    logic [31:0] dat;
    logic        to;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [3:0] m0_sel = 4'h0;
  logic [7:0] m0_adr = 8'h00;
  logic [31:0] m0_dat = 32'h0;
  logic m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [3:0] m1_sel = 4'h0;
  logic [7:0] m1_adr = 8'h00;
  logic [31:0] m1_dat = 32'h0;
  logic ram_ack = 1'b0;
  logic [31:0] ram_dat = 32'h0;

  logic m0_ack_o, m1_ack_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic rb_clk, rb_rst, rb_cyc, rb_stb, rb_we;
  logic [3:0] rb_sel;
  logic [7:0] rb_adr;
  logic [31:0] rb_dat;
  logic grant_o, busy_o, timeout_o;

  exp_t q0[$];
  exp_t q1[$];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rambus_arbiter dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .rambus_wb_clk_o(rb_clk), .rambus_wb_rst_o(rb_rst), .rambus_wb_cyc_o(rb_cyc),
    .rambus_wb_stb_o(rb_stb), .rambus_wb_we_o(rb_we), .rambus_wb_sel_o(rb_sel),
    .rambus_wb_adr_o(rb_adr), .rambus_wb_dat_o(rb_dat), .rambus_wb_ack_i(ram_ack),
    .rambus_wb_dat_i(ram_dat), .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  // RAM behaviour keyed on address: low bits 7 = never acks, 6 = acks on the
  // 16th cycle (collides with the timeout), otherwise acks after adr[1:0] waits.
  function automatic int lat_of(input logic [7:0] a);
    if (a[2:0] == 3'd7) return -1;
    else if (a[2:0] == 3'd6) return 15;
    else return int'(a[1:0]);
  endfunction

  function automatic logic [31:0] ram_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] sel, input logic [7:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_sel = sel; m0_adr = adr; m0_dat = dat;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_sel = sel; m1_adr = adr; m1_dat = dat;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller sits just after a rising edge; leaves the request asserted after
  // the ack so a zero-gap follow-up reuses the mandatory idle cycle.
  task automatic run_txn(input int m, input int gap, input logic we, input logic [3:0] sel,
                         input logic [7:0] adr, input logic [31:0] dat);
    exp_t e;
    logic got;
    if (gap > 0) begin
      drive(m, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
      idle_cycles(gap);
    end
    e.to  = (lat_of(adr) < 0);
    e.dat = e.to ? 32'hDEAD_BEEF : ram_word(adr);
    e.lat = e.to ? TMO : lat_of(adr) + 1;
    drive(m, 1'b1, 1'b1, we, sel, adr, dat);
    if (m == 0) q0.push_back(e); else q1.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack_o : m1_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now($sformatf("m%0d_ack_wait", m));
    idle_cycles(1);
  endtask

  task automatic master_rand(input int m, input int n);
    for (int i = 0; i < n; i++)
      run_txn(m, int'($urandom_range(0, 3)), 1'($urandom), 4'($urandom),
              8'($urandom), $urandom);
    drive(m, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
  endtask

  task automatic wait_busy(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now(name);
  endtask

  // RAM slave model: counts cycles of an open cycle, acks per address rule,
  // and throws spurious acks while the bus is idle
  initial begin : ram_model
    int cnt;
    int l;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rb_cyc) begin
        cnt++;
        l = lat_of(rb_adr);
        if (l >= 0 && cnt > l) begin
          ram_ack = 1'b1;
          ram_dat = ram_word(rb_adr);
        end else begin
          ram_ack = 1'b0;
          ram_dat = $urandom;
        end
      end else begin
        cnt = 0;
        ram_ack = ($urandom_range(0, 3) == 0);
        ram_dat = $urandom;
      end
    end
  end

  // Monitor: arbitration rules, bus routing and scoreboard pops
  initial begin : monitor
    logic rst_prev, busy_prev, ack_prev, last_served, cur_m, w, exp_to, exp_ack;
    logic [1:0] req_last;
    logic g_cyc, g_stb, g_we;
    logic [3:0] g_sel;
    logic [7:0] g_adr;
    logic [31:0] g_dat;
    int busy_len;
    exp_t e;
    rst_prev = 1'b0; busy_prev = 1'b0; ack_prev = 1'b0; last_served = 1'b1;
    cur_m = 1'b0; req_last = 2'b00; busy_len = 0;
    forever begin
      @(negedge clk);
      check("rst_o", rb_rst, !rst_n);
      check("clk_o", rb_clk, 1'b0);
      if (!rst_prev) begin
        check("rst_state", {busy_o, grant_o, timeout_o, m0_ack_o, m1_ack_o}, 5'b0);
        check("rst_ram_ctl", {rb_cyc, rb_stb, rb_we, rb_sel, rb_adr}, 15'h0);
        check("rst_ram_dat", rb_dat, 32'h0);
        check("rst_m_dat", m0_dat_o | m1_dat_o, 32'h0);
        last_served = 1'b1;
        busy_len = 0;
        ack_prev = 1'b0;
      end else begin
        if (busy_o && !busy_prev) begin
          if (req_last == 2'b00) begin
            fail_now("grant_without_request");
            cur_m = 1'b0;
          end else begin
            w = (req_last == 2'b11) ? !last_served : req_last[1];
            check("grant", grant_o, w);
            cur_m = w;
          end
          busy_len = 0;
        end
        if (!busy_prev && req_last != 2'b00) check("idle_to_busy", busy_o, 1'b1);
        if (ack_prev) check("idle_after_done", busy_o, 1'b0);
        if (busy_o) begin
          busy_len++;
          g_cyc = cur_m ? m1_cyc : m0_cyc;
          g_stb = cur_m ? m1_stb : m0_stb;
          g_we  = cur_m ? m1_we  : m0_we;
          g_sel = cur_m ? m1_sel : m0_sel;
          g_adr = cur_m ? m1_adr : m0_adr;
          g_dat = cur_m ? m1_dat : m0_dat;
          exp_to  = (busy_len == TMO) && g_cyc && !ram_ack;
          exp_ack = g_cyc && (ram_ack || exp_to);
          check("timeout_o", timeout_o, exp_to);
          check("ram_ctl", {rb_cyc, rb_stb, rb_we, rb_sel, rb_adr},
                {g_cyc, g_stb && !exp_to, g_we, g_sel, g_adr});
          check("ram_wdat", rb_dat, g_dat);
          check("granted_ack", cur_m ? m1_ack_o : m0_ack_o, exp_ack);
          check("other_ack", cur_m ? m0_ack_o : m1_ack_o, 1'b0);
          check("other_dat", cur_m ? m0_dat_o : m1_dat_o, 32'h0);
        end else begin
          check("idle_ram_ctl", {rb_cyc, rb_stb, rb_we, rb_sel, rb_adr}, 15'h0);
          check("idle_ram_dat", rb_dat, 32'h0);
          check("idle_resp", {m0_ack_o, m1_ack_o, timeout_o}, 3'b0);
          check("idle_m_dat", m0_dat_o | m1_dat_o, 32'h0);
        end
        if (m0_ack_o) begin
          if (q0.size() == 0) fail_now("m0_unexpected_ack");
          else begin
            e = q0.pop_front();
            check("m0_rdat", m0_dat_o, e.dat);
            check("m0_to_flag", timeout_o, e.to);
            check("m0_latency", busy_len, e.lat);
          end
        end
        if (m1_ack_o) begin
          if (q1.size() == 0) fail_now("m1_unexpected_ack");
          else begin
            e = q1.pop_front();
            check("m1_rdat", m1_dat_o, e.dat);
            check("m1_to_flag", timeout_o, e.to);
            check("m1_latency", busy_len, e.lat);
          end
        end
        if (busy_prev && !busy_o) last_served = cur_m;
      end
      ack_prev  = m0_ack_o | m1_ack_o;
      busy_prev = busy_o;
      req_last  = {m1_cyc & m1_stb, m0_cyc & m0_stb};
      rst_prev  = rst_n;
    end
  end

  // Stimulus sequence
  initial begin : stim
    idle_cycles(3);
    rst_n = 1'b1;
    // contention straight out of reset: M0, M1, M0, M1
    fork
      begin
        run_txn(0, 0, 1'b0, 4'hF, 8'h10, 32'h0);
        run_txn(0, 0, 1'b0, 4'hF, 8'h21, 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
      end
      begin
        run_txn(1, 0, 1'b0, 4'h3, 8'h32, 32'h0);
        run_txn(1, 0, 1'b0, 4'hC, 8'h43, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
      end
    join
    idle_cycles(3);
    // single read from M0 with two wait cycles
    run_txn(0, 0, 1'b0, 4'hF, 8'h12, 32'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    idle_cycles(2);
    // M1 back-to-back writes
    for (int i = 0; i < 4; i++)
      run_txn(1, 0, 1'b1, 4'(i + 1), 8'(8'h50 + i), 32'hA000_0000 + i);
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    idle_cycles(2);
    // never-acked transfer, then ack landing on the timeout cycle
    run_txn(0, 0, 1'b0, 4'hF, 8'h07, 32'h0);
    run_txn(0, 1, 1'b1, 4'h5, 8'h0E, 32'h1234_5678);
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    idle_cycles(2);
    // M0 aborts in its second busy cycle; M1 must then win the tie
    drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 8'h17, 32'h0);
    wait_busy("abort_busy_wait");
    idle_cycles(1);
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    idle_cycles(3);
    fork
      begin
        run_txn(0, 0, 1'b0, 4'hF, 8'h61, 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
      end
      begin
        run_txn(1, 0, 1'b0, 4'hF, 8'h72, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
      end
    join
    idle_cycles(2);
    // reset in the middle of an M1 transfer
    drive(1, 1'b1, 1'b1, 1'b1, 4'h3, 8'h27, 32'h1234);
    wait_busy("reset_busy_wait");
    idle_cycles(2);
    rst_n = 1'b0;
    idle_cycles(2);
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    rst_n = 1'b1;
    idle_cycles(3);
    // randomized traffic from both masters
    fork
      master_rand(0, 30);
      master_rand(1, 30);
    join
    idle_cycles(5);
    if (q0.size() != 0 || q1.size() != 0) fail_now("scoreboard_drain");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rambus_arbiter.md
RAMBUS_ARBITER -- requirements
Module: rambus_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 8, RAM word address width.
- DATA_W, default 32, data width.
- TIMEOUT, default 16, maximum cycles a grant waits for ack.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- wb_clk_i, in, 1, the single clock.
- wb_rst_ni, in, 1, reset; synchronous, active-low.
REQ-003 Master ports SHALL be provided for N=0 (Caravel bridge) and N=1 (generator sample fetch):
- mN_cyc_i, in, 1, Wishbone cycle.
- mN_stb_i, in, 1, Wishbone strobe.
- mN_we_i, in, 1, write enable.
- mN_sel_i, in, 4, byte select.
- mN_adr_i, in, ADDR_W, address.
- mN_dat_i, in, DATA_W, write data.
- mN_ack_o, out, 1, acknowledge.
- mN_dat_o, out, DATA_W, read data.
REQ-004 RAM-side ports SHALL be:
- rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o: out, 1 each.
- rambus_wb_sel_o, out, 4.
- rambus_wb_adr_o, out, ADDR_W.
- rambus_wb_dat_o, out, DATA_W.
- rambus_wb_ack_i, in, 1.
- rambus_wb_dat_i, in, DATA_W.
REQ-005 Status ports SHALL be:
- grant_o, out, 1, index of the owning master.
- busy_o, out, 1, high while in BUSY.
- timeout_o, out, 1, one-cycle pulse on timeout.

Function
REQ-006 rambus_wb_clk_o SHALL equal wb_clk_i, and rambus_wb_rst_o SHALL equal the inverse of wb_rst_ni.
REQ-007 The FSM SHALL have two states, IDLE and BUSY.
REQ-008 In IDLE, a request SHALL be mN_cyc_i & mN_stb_i. A pending request SHALL register the grant and move to BUSY on the next edge.
- Latency: request sampled at cycle n, rambus_wb_stb_o high in cycle n+1.
REQ-009 Arbitration SHALL be round-robin.
- With both masters requesting, the master not served last wins.
- With one master requesting, that master wins.
REQ-010 In BUSY, RAM cyc/stb/we/sel/adr/dat SHALL be driven combinationally from the granted master.
- In IDLE these outputs SHALL be all zero.
REQ-011 rambus_wb_ack_i and rambus_wb_dat_i SHALL be routed only to the granted master.
- The other master's ack_o and dat_o SHALL be 0.
REQ-012 rambus_wb_ack_i in BUSY SHALL complete the transfer: record last-served = grant, return to IDLE next edge.
- This guarantees one idle cycle between back-to-back grants.
REQ-013 rambus_wb_ack_i while in IDLE SHALL be ignored.
REQ-014 If the granted master deasserts cyc in BUSY (abort), the arbiter SHALL return to IDLE next edge with no ack and SHALL update last-served.
REQ-015 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
- Width SHALL be clog2(TIMEOUT+1).
REQ-016 When the counter reaches TIMEOUT-1 without ack, the arbiter SHALL, in that cycle:
- assert the granted mN_ack_o with mN_dat_o = TIMEOUT_DATA (32'hDEAD_BEEF);
- pulse timeout_o;
- deassert rambus_wb_stb_o;
- then enter IDLE.
REQ-017 Ack and timeout in the same cycle SHALL be treated as a normal ack: real data, no timeout_o.
REQ-018 A request from the non-granted master during BUSY SHALL be held pending, not dropped, and served after release.

Reset
REQ-019 When wb_rst_ni is low at a clock edge, the arbiter SHALL set state = IDLE, grant_o = 0, last-served = 1 (M0 wins first tie), counter = 0, and busy_o/timeout_o = 0.
- All master acks and all RAM outputs except clk/rst SHALL be 0.
REQ-020 Reset asserted mid-transaction SHALL abandon the transfer with no ack to either master.

Structure
REQ-021 Package rambus_pkg SHALL hold the state enum, TIMEOUT_DATA, and the default widths.
REQ-022 Two-way round-robin selection SHALL live in sub-module rr_pick2 (inputs req[1:0] and last; output winner).

Verification
REQ-023 Single read: M0 reads adr 0x10, RAM acks after 2 cycles with 0x12345678 -> m0_ack_o for 1 cycle, m0_dat_o = 0x12345678, m1_ack_o = 0.
REQ-024 Contention from reset: both masters request in the same cycle -> M0 served first, then M1, then M0 again if both are still requesting.
REQ-025 Back-to-back: M1 issues 4 consecutive writes -> exactly one IDLE cycle between each; rambus_wb_adr_o, sel and dat match M1 each transfer.
REQ-026 Timeout: RAM never acks with TIMEOUT=16 -> ack on the 16th BUSY cycle with data 0xDEADBEEF, timeout_o pulsed once, then IDLE.
REQ-027 Abort and reset:
- M0 drops cyc in the 2nd BUSY cycle -> IDLE, no ack.
- wb_rst_ni low mid-transfer -> all outputs 0 next edge, grant_o = 0.
